// File: rtl/count_ctrl_pkg.sv
// Shared types and elaboration helpers for the counter/BCD sequencer.
//   ctrl_state_t : control FSM states (IDLE holds the count, RUN counts)
//   cv_state_t   : serial converter FSM states
//   bcd_digits() : decimal digits needed to show 2**width-1
package count_ctrl_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } ctrl_state_t;

  typedef enum logic [1:0] {
    CV_IDLE,
    CV_SHIFT,
    CV_DONE
  } cv_state_t;

  function automatic int bcd_digits(input int width);
    longint unsigned maxv;
    int              d;
    maxv = (64'd1 << width) - 64'd1;
    d    = 1;
    while (maxv >= 64'd10) begin
      maxv = maxv / 64'd10;
      d    = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_serial_conv.sv
// Serial binary-to-BCD converter using shift-add-3 (double dabble).
// One input bit is consumed per cycle, so a conversion takes WIDTH shift
// cycles plus one cycle to publish the result.
//   clk, rst : clock and synchronous active-high reset
//   start    : snapshot bin and (re)start; restarting mid-conversion aborts it
//   bin      : binary value to convert
//   bcd      : last completed result (held until the next completion)
//   valid    : 1-cycle pulse when bcd has just been updated
//   busy     : conversion in progress
module bcd_serial_conv
  import count_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BCD_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH-1:0]        bin,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic                    valid,
  output logic                    busy
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  cv_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       bin_q, bin_d;
  logic [BCD_W-1:0]       sh_q, sh_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic [BCD_W+WIDTH-1:0] cat;

  // Correct every digit that would overflow past 9 once doubled.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    cat     = {add3(sh_q), bin_q} << 1;
    if (start) begin
      // A new request always wins, even in CV_DONE: the stale result is dropped.
      bin_d   = bin;
      sh_d    = '0;
      cnt_d   = '0;
      state_d = CV_SHIFT;
    end else begin
      case (state_q)
        CV_SHIFT: begin
          sh_d  = cat[BCD_W+WIDTH-1:WIDTH];
          bin_d = cat[WIDTH-1:0];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = CV_DONE;
        end
        CV_DONE: begin
          bcd_d   = sh_q;
          valid_d = 1'b1;
          state_d = CV_IDLE;
        end
        default: state_d = CV_IDLE;
      endcase
    end
    busy_d = (state_d != CV_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CV_IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Working registers are always rewritten on start, so they need no reset.
  always_ff @(posedge clk) begin
    bin_q <= bin_d;
    sh_q  <= sh_d;
  end

  assign bcd   = bcd_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: rtl/count_seq_ctrl.sv
// Sequencer for the preloadable up-counter and its BCD display path.
// Owns the count register, run/stop control and the increment prescaler,
// and launches a serial BCD conversion whenever the count changes.
//   clk, rst  : clock and synchronous active-high reset
//   start     : enter RUN          stop     : enter IDLE, hold count
//   load_req  : preload load_val   load_val : preload value
//   count_out : current count      bcd_out  : last completed BCD of the count
//   bcd_valid : bcd_out updated    busy     : conversion in progress
//   wrap      : 1-cycle pulse when the count rolls over max->0
module count_seq_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BCD_DIGITS = 3,
  parameter int PRESCALE   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    load_req,
  input  logic [WIDTH-1:0]        load_val,
  output logic [WIDTH-1:0]        count_out,
  output logic [4*BCD_DIGITS-1:0] bcd_out,
  output logic                    bcd_valid,
  output logic                    busy,
  output logic                    wrap
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  if (BCD_DIGITS < bcd_digits(WIDTH)) begin : g_bcd_digits_check
    $error("BCD_DIGITS too small to represent 2**WIDTH-1");
  end
  if (PRESCALE < 1) begin : g_prescale_check
    $error("PRESCALE must be at least 1");
  end

  ctrl_state_t      state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             wrap_q, wrap_d;
  logic             conv_start_q, conv_start_d;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    ps_d         = ps_q;
    wrap_d       = 1'b0;
    conv_start_d = 1'b0;
    if (load_req) begin
      count_d      = load_val;
      ps_d         = '0;
      conv_start_d = 1'b1;
      if (stop)       state_d = IDLE;
      else if (start) state_d = RUN;
    end else if (stop) begin
      // Stop outranks a coincident tick; the prescaler phase is kept for restart.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) state_d = RUN;
        RUN: begin
          if (ps_q == PS_MAX) begin
            ps_d         = '0;
            count_d      = count_q + WIDTH'(1);
            conv_start_d = 1'b1;
            wrap_d       = (count_q == '1);
          end else begin
            ps_d = ps_q + PS_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      ps_q         <= '0;
      wrap_q       <= 1'b0;
      conv_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      ps_q         <= ps_d;
      wrap_q       <= wrap_d;
      conv_start_q <= conv_start_d;
    end
  end

  // conv_start_q is high in the first cycle the new count is visible, so the
  // converter snapshots exactly the value shown on count_out.
  bcd_serial_conv #(
    .WIDTH      (WIDTH),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start_q),
    .bin   (count_q),
    .bcd   (bcd_out),
    .valid (bcd_valid),
    .busy  (busy)
  );

  assign count_out = count_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
module tb_count_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, stop = 1'b0, load_req = 1'b0;
  logic [7:0]  load_val = 8'd0;
  logic [7:0]  count_out;
  logic [11:0] bcd_out;
  logic        bcd_valid, busy, wrap;

  logic        p_start = 1'b0, p_stop = 1'b0, p_load_req = 1'b0;
  logic [7:0]  p_load_val = 8'd0;
  logic [7:0]  p_count_out;
  logic [11:0] p_bcd_out;
  logic        p_bcd_valid, p_busy, p_wrap;

  int checks = 0;
  int failures = 0;
  int vcnt = 0;
  int p_vcnt = 0;

  always #5 clk = ~clk;

  count_seq_ctrl #(.WIDTH(8), .BCD_DIGITS(3), .PRESCALE(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .load_req(load_req),
    .load_val(load_val), .count_out(count_out), .bcd_out(bcd_out),
    .bcd_valid(bcd_valid), .busy(busy), .wrap(wrap)
  );

  count_seq_ctrl #(.WIDTH(8), .BCD_DIGITS(3), .PRESCALE(1)) dut_p1 (
    .clk(clk), .rst(rst), .start(p_start), .stop(p_stop), .load_req(p_load_req),
    .load_val(p_load_val), .count_out(p_count_out), .bcd_out(p_bcd_out),
    .bcd_valid(p_bcd_valid), .busy(p_busy), .wrap(p_wrap)
  );

  always @(negedge clk) begin
    if (bcd_valid === 1'b1) vcnt = vcnt + 1;
    if (p_bcd_valid === 1'b1) p_vcnt = p_vcnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    bit got_valid;

    // 1: reset and idle
    rst = 1'b1;
    step(2);
    check("rst_count", count_out, 0);
    check("rst_bcd", bcd_out, 0);
    check("rst_valid", bcd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_wrap", wrap, 0);
    rst = 1'b0;
    vcnt = 0;
    step(20);
    check("idle_count", count_out, 0);
    check("idle_no_valid", vcnt, 0);
    check("idle_busy", busy, 0);

    // 2: load 200 in IDLE
    load_req = 1'b1; load_val = 8'd200;
    step(1);
    load_req = 1'b0;
    vcnt = 0;
    check("load200_count", count_out, 200);
    check("load200_busy", busy, 0);
    step(1);
    check("load200_busy_on", busy, 1);
    step(8);
    check("load200_valid_early", bcd_valid, 0);
    step(1);
    check("load200_valid", bcd_valid, 1);
    check("load200_bcd", bcd_out, 32'h200);
    step(1);
    check("load200_valid_pulse", bcd_valid, 0);
    check("load200_busy_off", busy, 0);
    step(10);
    check("load200_hold", count_out, 200);
    check("load200_one_valid", vcnt, 1);

    // 3: run, stop, resume with preserved prescaler phase
    do_reset();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(15);
    check("run_c0", count_out, 0);
    step(1);
    check("run_c1", count_out, 1);
    step(16);
    check("run_c2", count_out, 2);
    step(16);
    check("run_c3", count_out, 3);
    step(5);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(30);
    check("stop_frozen", count_out, 3);
    check("stop_bcd", bcd_out, 32'h003);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(10);
    check("resume_before", count_out, 3);
    step(1);
    check("resume_c4", count_out, 4);

    // 4: load 255 with start, wrap
    do_reset();
    load_req = 1'b1; load_val = 8'd255; start = 1'b1;
    step(1);
    load_req = 1'b0; start = 1'b0;
    check("wrap_load", count_out, 255);
    step(15);
    check("wrap_pre", count_out, 255);
    check("wrap_pre_flag", wrap, 0);
    check("wrap_bcd255", bcd_out, 32'h255);
    step(1);
    check("wrap_count0", count_out, 0);
    check("wrap_flag", wrap, 1);
    step(1);
    check("wrap_flag_pulse", wrap, 0);
    step(9);
    check("wrap_valid", bcd_valid, 1);
    check("wrap_bcd000", bcd_out, 32'h000);

    // 5: back-to-back loads abort the first conversion
    do_reset();
    load_req = 1'b1; load_val = 8'd123;
    step(1);
    load_req = 1'b0;
    vcnt = 0;
    step(3);
    load_req = 1'b1; load_val = 8'd99;
    step(1);
    load_req = 1'b0;
    check("abort_count", count_out, 99);
    step(9);
    check("abort_valid_early", bcd_valid, 0);
    step(1);
    check("abort_valid", bcd_valid, 1);
    check("abort_bcd", bcd_out, 32'h099);
    step(1);
    check("abort_one_valid", vcnt, 1);
    // reloading the same value still launches a conversion
    load_req = 1'b1; load_val = 8'd99;
    step(1);
    load_req = 1'b0;
    step(10);
    check("same_val_valid", bcd_valid, 1);
    check("same_val_bcd", bcd_out, 32'h099);

    // 6: PRESCALE=1 instance
    do_reset();
    p_start = 1'b1;
    step(1);
    p_start = 1'b0;
    p_vcnt = 0;
    step(299);
    check("p1_count", p_count_out, 43);
    check("p1_no_valid_running", p_vcnt, 0);
    p_stop = 1'b1;
    step(1);
    p_stop = 1'b0;
    check("p1_stopped", p_count_out, 43);
    got_valid = 1'b0;
    for (int i = 0; i < 12 && !got_valid; i++) begin
      step(1);
      if (p_bcd_valid === 1'b1) got_valid = 1'b1;
    end
    check("p1_valid_seen", got_valid, 1);
    check("p1_bcd", p_bcd_out, 32'h043);

    p_load_req = 1'b1; p_load_val = 8'd77;
    step(1);
    p_load_req = 1'b0;
    step(3);
    check("p1_mid_busy", p_busy, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("p1_rst_count", p_count_out, 0);
    check("p1_rst_bcd", p_bcd_out, 0);
    check("p1_rst_valid", p_bcd_valid, 0);
    check("p1_rst_busy", p_busy, 0);
    check("p1_rst_wrap", p_wrap, 0);
    p_vcnt = 0;
    step(15);
    check("p1_rst_no_valid", p_vcnt, 0);
    check("p1_rst_bcd_hold", p_bcd_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
